delay_line_var: RTL



---
 rtl/delay_line_var.sv | 95 +++++++++
 1 files changed

// File: rtl/delay_line_var.sv
// delay_line_var: runtime-programmable delay line for signed samples.
// Delays {valid_in, data_in} by min(delay_sel, MAX_DEPTH) enabled edges.
// Ports: clk, reset (async, active-high), en (advance), flush (sync clear),
//   delay_sel (requested delay), data_in/valid_in (sample in),
//   data_out/valid_out (delayed sample, combinational tap), primed.
// Option: DELAY_LINE_ZERO_FILL_EN forces data_out to 0 when the tap is
//   not valid.
module delay_line_var #(
  parameter int WIDTH     = 25,
  parameter int MAX_DEPTH = 16,
  parameter int SELW      = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [SELW-1:0]  delay_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             primed
);

  localparam logic [SELW-1:0] MAXD = SELW'(MAX_DEPTH);

  logic [WIDTH:0]  stg_q [MAX_DEPTH];
  logic [WIDTH:0]  stg_d [MAX_DEPTH];
  logic [SELW-1:0] fill_q, fill_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] d_eff;
  logic [WIDTH:0]  tap;

  always_comb begin
    d_eff = (delay_sel > MAXD) ? MAXD : delay_sel;
  end

  always_comb begin
    stg_d = stg_q;
    if (flush) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stg_d[i] = '0;
      end
    end else if (en) begin
      stg_d[0] = {valid_in, data_in};
      for (int i = 1; i < MAX_DEPTH; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  // Any change of the requested delay restarts the history count.
  always_comb begin
    fill_d = fill_q;
    sel_d  = delay_sel;
    if (flush || (delay_sel != sel_q)) begin
      fill_d = '0;
    end else if (en && (fill_q != MAXD)) begin
      fill_d = fill_q + SELW'(1);
    end
  end

  // Tap select; D_eff = 0 bypasses the registers entirely.
  always_comb begin
    tap = {valid_in, data_in};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (d_eff == SELW'(i + 1)) begin
        tap = stg_q[i];
      end
    end
  end

  assign valid_out = tap[WIDTH];
`ifdef DELAY_LINE_ZERO_FILL_EN
  assign data_out  = tap[WIDTH] ? tap[WIDTH-1:0] : '0;
`else
  assign data_out  = tap[WIDTH-1:0];
`endif
  assign primed    = (fill_q >= d_eff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stg_q[i] <= '0;
      end
      fill_q <= '0;
      sel_q  <= '0;
    end else begin
      stg_q  <= stg_d;
      fill_q <= fill_d;
      sel_q  <= sel_d;
    end
  end

endmodule
